// File: rtl/mem_stage_pkg.sv
// ============================================================================
// mem_stage_pkg -- control-word, access-size and state types for mem_stage
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } rvga_mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } rvga_mem_state_e;

  typedef struct packed {
    logic           v;
    logic           rd_w_v;
    logic           mem_r_v;
    logic           mem_w_v;
    rvga_mem_size_e mem_size;
    logic           mem_unsigned;
    logic           mem_misalign;
    logic [31:0]    alu_result;
    logic [31:0]    rs2_data;
    logic [31:0]    rd_data;
  } rvga_cword;

  function automatic logic is_misaligned(input rvga_mem_size_e size, input logic [1:0] addr_lo);
    case (size)
      MEM_H:   return addr_lo[0];
      MEM_W:   return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// mem_lane_align -- store lane replication/byte enables, load extract/extend
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
  import mem_stage_pkg::*;
(
  input  rvga_mem_size_e size,
  input  logic           is_unsigned,
  input  logic [1:0]     addr_lo,
  input  logic [31:0]    store_data,
  input  logic [31:0]    rdata,
  output logic [31:0]    wdata,
  output logic [3:0]     wmask,
  output logic [31:0]    load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[7:0];
    case (addr_lo)
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      2'd3:    w_byte = rdata[31:24];
      default: w_byte = rdata[7:0];
    endcase
    w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wdata     = store_data;
    wmask     = 4'hF;
    load_data = rdata;
    case (size)
      MEM_B: begin
        wdata     = {4{store_data[7:0]}};
        wmask     = 4'b0001 << addr_lo;
        load_data = {{24{~is_unsigned & w_byte[7]}}, w_byte};
      end
      MEM_H: begin
        wdata     = {2{store_data[15:0]}};
        wmask     = addr_lo[1] ? 4'b1100 : 4'b0011;
        load_data = {{16{~is_unsigned & w_half[15]}}, w_half};
      end
      default: begin
        wdata     = store_data;
        wmask     = 4'hF;
        load_data = rdata;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage -- load/store issue over a valid/ready dmem port, one access in flight.
// Optional RVGA_MEM_MISALIGN_TRAP_EN: misaligned H/W ops skip dmem and emit flagged.
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    stall_v_i,
  input  rvga_cword               cword_i,
  output rvga_cword               cword_o,
  output logic                    stall_v_o,
  output logic                    dmem_req_v_o,
  input  logic                    dmem_ready_i,
  output logic                    dmem_w_o,
  output logic [addr_width_p-1:0] dmem_addr_o,
  output logic [data_width_p-1:0] dmem_wdata_o,
  output logic [3:0]              dmem_wmask_o,
  input  logic                    dmem_resp_v_i,
  input  logic [data_width_p-1:0] dmem_rdata_i
);

  rvga_mem_state_e r_state, w_next;
  rvga_cword       r_cap;
  rvga_cword       w_cap_emit;

  logic            w_is_mem, w_misalign, w_req, w_capture, w_buffer;
  logic            w_src_w, w_src_unsigned;
  rvga_mem_size_e  w_src_size;
  logic [31:0]     w_src_addr, w_src_rs2;
  logic [31:0]     w_wdata, w_load_data;
  logic [3:0]      w_wmask;

  assign w_is_mem = cword_i.v & (cword_i.mem_r_v | cword_i.mem_w_v);

`ifdef RVGA_MEM_MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(cword_i.mem_size, cword_i.alu_result[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  // IDLE issues straight from the incoming cword; later states replay the capture
  assign w_src_w        = (r_state == ST_IDLE) ? cword_i.mem_w_v      : r_cap.mem_w_v;
  assign w_src_size     = (r_state == ST_IDLE) ? cword_i.mem_size     : r_cap.mem_size;
  assign w_src_unsigned = (r_state == ST_IDLE) ? cword_i.mem_unsigned : r_cap.mem_unsigned;
  assign w_src_addr     = (r_state == ST_IDLE) ? cword_i.alu_result   : r_cap.alu_result;
  assign w_src_rs2      = (r_state == ST_IDLE) ? cword_i.rs2_data     : r_cap.rs2_data;

  mem_lane_align u_align (
    .size        (w_src_size),
    .is_unsigned (w_src_unsigned),
    .addr_lo     (w_src_addr[1:0]),
    .store_data  (w_src_rs2),
    .rdata       (dmem_rdata_i),
    .wdata       (w_wdata),
    .wmask       (w_wmask),
    .load_data   (w_load_data)
  );

  always_comb begin
    w_next     = r_state;
    cword_o    = cword_i;
    stall_v_o  = 1'b0;
    w_req      = 1'b0;
    w_capture  = 1'b0;
    w_buffer   = 1'b0;
    w_cap_emit = r_cap;
    w_cap_emit.v = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (w_is_mem) begin
          cword_o.v = 1'b0;
          if (!stall_v_i) begin
            if (w_misalign) begin
              cword_o.v            = 1'b1;
              cword_o.mem_misalign = 1'b1;
              cword_o.rd_w_v       = 1'b0;
            end else begin
              w_req     = 1'b1;
              w_capture = 1'b1;
              if (dmem_ready_i && cword_i.mem_w_v) begin
                cword_o.v = 1'b1;
              end else begin
                stall_v_o = 1'b1;
                w_next    = dmem_ready_i ? ST_RESP : ST_REQ;
              end
            end
          end
        end
      end
      ST_REQ: begin
        w_req     = 1'b1;
        stall_v_o = 1'b1;
        cword_o   = r_cap;
        cword_o.v = 1'b0;
        if (dmem_ready_i) begin
          if (!r_cap.mem_w_v) begin
            w_next = ST_RESP;
          end else if (!stall_v_i) begin
            cword_o   = w_cap_emit;
            stall_v_o = 1'b0;
            w_next    = ST_IDLE;
          end else begin
            w_next = ST_HOLD;
          end
        end
      end
      ST_RESP: begin
        stall_v_o = 1'b1;
        cword_o   = r_cap;
        cword_o.v = 1'b0;
        if (dmem_resp_v_i) begin
          if (!stall_v_i) begin
            cword_o         = w_cap_emit;
            cword_o.rd_data = w_load_data;
            stall_v_o       = 1'b0;
            w_next          = ST_IDLE;
          end else begin
            w_buffer = 1'b1;
            w_next   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        stall_v_o = 1'b1;
        cword_o   = r_cap;
        cword_o.v = 1'b0;
        if (!stall_v_i) begin
          cword_o   = w_cap_emit;
          stall_v_o = 1'b0;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
    // Reset must silence the port at once, even with a valid cword still presented
    if (!rst_i) begin
      cword_o.v = 1'b0;
      stall_v_o = 1'b0;
      w_req     = 1'b0;
      w_capture = 1'b0;
      w_buffer  = 1'b0;
    end
  end

  assign dmem_req_v_o = w_req;
  assign dmem_w_o     = w_src_w;
  assign dmem_addr_o  = {w_src_addr[addr_width_p-1:2], 2'b00};
  assign dmem_wdata_o = w_wdata;
  assign dmem_wmask_o = w_src_w ? w_wmask : 4'h0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_cap   <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture)
        r_cap <= cword_i;
      else if (w_buffer)
        r_cap.rd_data <= w_load_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// tb_mem_stage -- directed corner cases plus randomized traffic for mem_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, stall_v_i, stall_v_o;
  rvga_cword   cword_i, cword_o;
  logic        req_v, ready, w, resp_v;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  wmask;

  always #5 clk = ~clk;

  mem_stage #(.addr_width_p(32), .data_width_p(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_v_i(stall_v_i), .cword_i(cword_i), .cword_o(cword_o),
    .stall_v_o(stall_v_o), .dmem_req_v_o(req_v), .dmem_ready_i(ready), .dmem_w_o(w),
    .dmem_addr_o(addr), .dmem_wdata_o(wdata), .dmem_wmask_o(wmask),
    .dmem_resp_v_i(resp_v), .dmem_rdata_i(rdata)
  );

  int          checks = 0, failures = 0;
  rvga_cword   exp_q[$];
  logic [31:0] ref_mem[64];
  logic [31:0] dut_mem[64];
  int          n_issued = 0, n_accepted = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model: byte-level memory semantics ----------------
  function automatic int nbytes(input rvga_mem_size_e s);
    return (s == MEM_B) ? 1 : (s == MEM_H) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input rvga_mem_size_e s,
                                           input logic [1:0] a, input logic u);
    int n, base;
    longint val, span;
    n    = nbytes(s);
    base = (int'(a) / n) * n;
    span = longint'(1) << (8 * n);
    val  = longint'(word >> (8 * base)) & (span - 1);
    if (!u && val[8*n-1]) val = val - span;
    return val[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input rvga_mem_size_e s,
                                            input logic [1:0] a, input logic [31:0] rs2);
    int n, base;
    n    = nbytes(s);
    base = (int'(a) / n) * n;
    for (int i = 0; i < 4; i++)
      if (i >= base && i < base + n) word[8*i +: 8] = rs2[8*(i-base) +: 8];
    return word;
  endfunction

  function automatic rvga_cword model(input rvga_cword c);
    rvga_cword e;
    int idx;
    e   = c;
    idx = int'(c.alu_result[7:2]);
    if (!(c.mem_r_v || c.mem_w_v)) return e;
`ifdef RVGA_MEM_MISALIGN_TRAP_EN
    if ((int'(c.alu_result[1:0]) % nbytes(c.mem_size)) != 0) begin
      e.mem_misalign = 1'b1;
      e.rd_w_v       = 1'b0;
      return e;
    end
`endif
    n_issued++;
    if (c.mem_w_v)
      ref_mem[idx] = ref_store(ref_mem[idx], c.mem_size, c.alu_result[1:0], c.rs2_data);
    else
      e.rd_data = ref_load(ref_mem[idx], c.mem_size, c.alu_result[1:0], c.mem_unsigned);
    return e;
  endfunction

  task automatic issue(input rvga_cword c);
    cword_i = c;
    if (c.v) exp_q.push_back(model(c));
  endtask

  function automatic rvga_cword mk(input logic ld, input rvga_mem_size_e s, input logic u,
                                   input logic [31:0] a, input logic [31:0] rs2);
    rvga_cword c;
    c = '0;
    c.v = 1'b1; c.rd_w_v = ld; c.mem_r_v = ld; c.mem_w_v = ~ld;
    c.mem_size = s; c.mem_unsigned = u; c.alu_result = a; c.rs2_data = rs2;
    c.rd_data = 32'h5A5A_0000;
    return c;
  endfunction

  function automatic rvga_cword rand_cword();
    rvga_cword c;
    int k;
    k = int'($urandom % 10);
    c = '0;
    c.v            = (k != 0);
    c.rd_data      = $urandom;
    c.rs2_data     = $urandom;
    c.alu_result   = 32'h0000_0100 | {24'h0, 8'($urandom)};
    c.mem_size     = rvga_mem_size_e'($urandom % 3);
    c.mem_unsigned = 1'($urandom);
    c.mem_r_v      = (k >= 4 && k <= 6);
    c.mem_w_v      = (k >= 7);
    c.rd_w_v       = c.mem_r_v | (k < 4 && 1'($urandom));
    return c;
  endfunction

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_i && cword_o.v && !stall_v_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL emit_unexpected actual=%0h required=none", cword_o);
        end else begin
          chk("emit_cword", cword_o, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- random-phase driver and dmem responder ----------------
  bit          advance = 1'b1, pend_load = 1'b0, prev_pend = 1'b0;
  int          pend_idx, dly;
  logic [70:0] prev_req;

  task automatic rand_cycle(input bit gen);
    int idx;
    if (advance) begin
      if (gen) issue(rand_cword());
      else cword_i = '0;
    end
    stall_v_i = ($urandom % 4 == 0);
    ready     = ($urandom % 3 != 0);
    if (pend_load && dly == 0) begin
      resp_v = 1'b1; rdata = dut_mem[pend_idx]; pend_load = 1'b0;
    end else begin
      if (pend_load) dly--;
      resp_v = !pend_load && ($urandom % 5 == 0);
      rdata  = $urandom;
    end
    @(negedge clk);
    if (prev_pend && req_v) chk("req_stable", {w, addr, wdata, wmask, 2'b00}, prev_req);
    if (req_v) begin
      chk("req_addr_aligned", addr[1:0], 2'b00);
      if (!w) chk("load_mask_zero", wmask, 4'h0);
    end
    if (req_v && ready) begin
      n_accepted++;
      idx = int'(addr[7:2]);
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (wmask[i]) dut_mem[idx][8*i +: 8] = wdata[8*i +: 8];
      end else begin
        pend_load = 1'b1; pend_idx = idx; dly = int'($urandom % 3);
      end
    end
    prev_pend = req_v && !ready;
    prev_req  = {w, addr, wdata, wmask, 2'b00};
    advance   = !stall_v_o && !stall_v_i;
    @(posedge clk); #1;
  endtask

  // directed single load: accepted at once, response the next cycle
  task automatic quick_load(input rvga_cword c, input logic [31:0] word, input logic [31:0] rd,
                            input string name);
    issue(c); ready = 1'b1; resp_v = 1'b0;
    @(negedge clk);
    chk({name, "_addr"}, addr, {c.alu_result[31:2], 2'b00});
    chk({name, "_stall_T"}, stall_v_o, 1'b1);
    @(posedge clk); #1;
    ready = 1'b0; resp_v = 1'b1; rdata = word;
    @(negedge clk);
    chk({name, "_stall_T1"}, stall_v_o, 1'b0);
    chk({name, "_rd"}, cword_o.rd_data, rd);
    @(posedge clk); #1;
    cword_i = '0; resp_v = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0; stall_v_i = 1'b0; ready = 1'b0; resp_v = 1'b0; rdata = '0;
    cword_i = mk(1'b1, MEM_W, 1'b0, 32'h100, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_v", req_v, 1'b0);
    chk("reset_stall", stall_v_o, 1'b0);
    chk("reset_cword_v", cword_o.v, 1'b0);
    cword_i = '0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;

    // lb / lbu lane 3 of 0x80FF1234
    ref_mem[0] = 32'h80FF1234;
    quick_load(mk(1'b1, MEM_B, 1'b0, 32'h1003, 0), 32'h80FF1234, 32'hFFFFFF80, "lb");
    quick_load(mk(1'b1, MEM_B, 1'b1, 32'h1003, 0), 32'h80FF1234, 32'h00000080, "lbu");

    // sh upper half, emitted in the acceptance cycle
    issue(mk(1'b0, MEM_H, 1'b0, 32'h2002, 32'hABCD1234)); ready = 1'b1;
    @(negedge clk);
    chk("sh_addr", addr, 32'h2000);
    chk("sh_wdata", wdata, 32'h12341234);
    chk("sh_mask", wmask, 4'b1100);
    chk("sh_stall", stall_v_o, 1'b0);
    chk("sh_emit", cword_o.v, 1'b1);
    @(posedge clk); #1;
    cword_i = '0; ready = 1'b0;

    // lw with ready low for 3 cycles
    ref_mem[4] = 32'h11223344;
    issue(mk(1'b1, MEM_W, 1'b0, 32'h1010, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lw_wait_req", {req_v, stall_v_o, cword_o.v, addr, wmask}, {3'b110, 32'h1010, 4'h0});
      @(posedge clk); #1;
    end
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0; resp_v = 1'b1; rdata = 32'h11223344;
    @(negedge clk);
    chk("lw_wait_req_gone", req_v, 1'b0);
    chk("lw_wait_rd", cword_o.rd_data, 32'h11223344);
    @(posedge clk); #1;
    cword_i = '0; resp_v = 1'b0;

    // lhu response arrives under downstream stall
    ref_mem[0] = 32'hBEEF0000;
    issue(mk(1'b1, MEM_H, 1'b1, 32'h3002, 0)); ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0; resp_v = 1'b1; rdata = 32'hBEEF0000; stall_v_i = 1'b1;
    @(negedge clk);
    chk("hold_stall_1", {stall_v_o, cword_o.v}, 2'b10);
    @(posedge clk); #1;
    resp_v = 1'b0; rdata = 32'h0;
    @(negedge clk);
    chk("hold_stall_2", {stall_v_o, cword_o.v}, 2'b10);
    @(posedge clk); #1;
    stall_v_i = 1'b0;
    @(negedge clk);
    chk("hold_rd", {stall_v_o, cword_o.rd_data}, {1'b0, 32'h0000BEEF});
    @(posedge clk); #1;
    cword_i = '0;

    // reset while waiting on a load response; stale response afterwards
    cword_i = mk(1'b1, MEM_W, 1'b0, 32'h1020, 0); ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    rst_i = 1'b0;
    #1;
    chk("rst_mid_req_v", req_v, 1'b0);
    chk("rst_mid_cword_v", {cword_o.v, stall_v_o}, 2'b00);
    @(posedge clk); #1;
    rst_i = 1'b1; cword_i = '0; resp_v = 1'b1; rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("stale_resp_ignored", {cword_o.v, stall_v_o, req_v}, 3'b000);
    @(posedge clk); #1;
    resp_v = 1'b0;

    // misaligned word load
    ref_mem[0] = 32'hCAFEF00D;
    issue(mk(1'b1, MEM_W, 1'b0, 32'h1002, 0)); ready = 1'b1;
    @(negedge clk);
`ifdef RVGA_MEM_MISALIGN_TRAP_EN
    chk("misalign_trap", {req_v, cword_o.v, cword_o.mem_misalign, cword_o.rd_w_v}, 4'b0110);
    @(posedge clk); #1;
    cword_i = '0; ready = 1'b0;
`else
    chk("misalign_ignored_addr", {req_v, addr}, {1'b1, 32'h1000});
    @(posedge clk); #1;
    ready = 1'b0; resp_v = 1'b1; rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("misalign_ignored_rd", cword_o.rd_data, 32'hCAFEF00D);
    @(posedge clk); #1;
    cword_i = '0; resp_v = 1'b0;
`endif
    @(posedge clk); #1;
    chk("directed_drained", exp_q.size(), 0);

    // randomized traffic against the byte-level memory model
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      dut_mem[i] = ref_mem[i];
    end
    n_issued = 0; n_accepted = 0; advance = 1'b1;
    for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || !advance); i++) rand_cycle(1'b0);
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("accepted_requests", n_accepted, n_issued);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
